// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit with HI/LO registers, one step per clock.
// Define MDU_DIV0_FLAG_EN to add the sticky div0 output.
module mdu_hilo #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              mthi,
   input  logic              mtlo,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
   ,
   output logic              div0
`endif
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]       cnt_q, cnt_d;
   logic [2*DATA_W-1:0] p_q, p_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic                div_q, div_d;
   logic                sa_q, sa_d;
   logic                sb_q, sb_d;
   logic                done_q, done_d;
   logic                div0_q, div0_d;

   logic                sgn_a, sgn_b;
   logic [DATA_W-1:0]   abs_a, abs_b;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     rem_sh;
   logic [DATA_W:0]     diff;
   logic                q_bit;
   logic [DATA_W-1:0]   new_rem;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;
   logic [DATA_W-1:0]   a_raw;
   logic                b_zero;

   assign sgn_a = ~op[0] & rs_data[DATA_W-1];
   assign sgn_b = ~op[0] & rt_data[DATA_W-1];
   assign abs_a = sgn_a ? -rs_data : rs_data;
   assign abs_b = sgn_b ? -rt_data : rt_data;

   // Multiply: p = {acc, multiplier}, add multiplicand then shift right.
   assign mul_sum = {1'b0, p_q[2*DATA_W-1:DATA_W]}
                  + (p_q[0] ? {1'b0, a_q} : '0);

   // Divide: p = {remainder, dividend/quotient}, restoring step.
   assign rem_sh  = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
   assign diff    = rem_sh - {1'b0, b_q};
   assign q_bit   = ~diff[DATA_W];
   assign new_rem = q_bit ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];

   assign prod_fix = (sa_q ^ sb_q) ? -p_q : p_q;
   assign quo_fix  = (sa_q ^ sb_q) ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
   assign rem_fix  = sa_q ? -p_q[2*DATA_W-1:DATA_W]
                          : p_q[2*DATA_W-1:DATA_W];
   // Negating |rs| restores the raw operand, including the most negative value.
   assign a_raw    = sa_q ? -a_q : a_q;
   assign b_zero   = (b_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      done_d  = 1'b0;
      div0_d  = div0_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               sa_d    = sgn_a;
               sb_d    = sgn_b;
               a_d     = abs_a;
               b_d     = abs_b;
               div_d   = op[1];
               p_d     = op[1] ? {{DATA_W{1'b0}}, abs_a}
                               : {{DATA_W{1'b0}}, abs_b};
               cnt_d   = '0;
               div0_d  = 1'b0;
               state_d = S_RUN;
            end else begin
               if (mthi) hi_d = wr_data;
               if (mtlo) lo_d = wr_data;
            end
         end
         S_RUN: begin
            if (div_q) begin
               p_d = {new_rem, p_q[DATA_W-2:0], q_bit};
            end else begin
               p_d = {mul_sum, p_q[DATA_W-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_FIX;
         end
         S_FIX: begin
            if (div_q && b_zero) begin
               hi_d   = a_raw;
               lo_d   = '1;
               div0_d = 1'b1;
            end else if (div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         done_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         div_q   <= div_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         done_q  <= done_d;
         div0_q  <= div0_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

`ifdef MDU_DIV0_FLAG_EN
   assign div0 = div0_q;
`else
   logic unused_div0;
   assign unused_div0 = div0_q;
`endif

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: arithmetic reference model plus directed vectors.
// Define MDU_DIV0_FLAG_EN to also check the div0 flag.
module tb_mdu_hilo;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] rs = '0;
   logic [W-1:0] rt = '0;
   logic         mthi = 1'b0;
   logic         mtlo = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
   logic         div0;
`endif

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mdu_hilo #(.DATA_W(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .rs_data (rs),
      .rt_data (rt),
      .mthi    (mthi),
      .mtlo    (mtlo),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
`ifdef MDU_DIV0_FLAG_EN
      ,
      .div0    (div0)
`endif
   );

   // Result {hi,lo} straight from the arithmetic definition of each op.
   function automatic logic [63:0] ref_op(input logic [1:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic signed [63:0] sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = {{32{a[W-1]}}, a};
      sb = {{32{b[W-1]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (o)
         2'd0: return sa * sb;
         2'd1: return ua * ub;
         default: begin
            if (b == '0) return {a, 32'hFFFF_FFFF};
            if (o == 2'd2) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic [63:0]  m_res = '0;
   int           m_left = 0;
   bit           m_done = 1'b0;
   bit           m_pz = 1'b0;
   bit           m_div0 = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_hi = '0;
         m_lo = '0;
         m_left = 0;
         m_done = 1'b0;
         m_div0 = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               {m_hi, m_lo} = m_res;
               m_done = 1'b1;
               if (m_pz) m_div0 = 1'b1;
            end
         end else if (start) begin
            m_res  = ref_op(op, rs, rt);
            m_pz   = op[1] && (rt == '0);
            m_left = W + 1;
            m_div0 = 1'b0;
         end else begin
            if (mthi) m_hi = wr_data;
            if (mtlo) m_lo = wr_data;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(m_left > 0));
         chk("done", 64'(done), 64'(m_done));
         chk("hi", 64'(hi), 64'(m_hi));
         chk("lo", 64'(lo), 64'(m_lo));
`ifdef MDU_DIV0_FLAG_EN
         chk("div0", 64'(div0), 64'(m_div0));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_op(input string nm, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
      int lat;
      start = 1'b1;
      op = o;
      rs = a;
      rt = b;
      tick();
      start = 1'b0;
      mthi = 1'b0;
      mtlo = 1'b0;
      chk({nm, "_busy0"}, 64'(busy), 64'd1);
      wait_done(lat);
      chk({nm, "_lat"}, 64'(lat), 64'd33);
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      int lat;
      bit seen;
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);

      do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7,
            32'hFFFF_FFFF, 32'hFFFF_FFEB);
      do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001);
      do_op("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      do_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000);
      do_op("divu_z", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
`ifdef MDU_DIV0_FLAG_EN
      chk("div0_set", 64'(div0), 64'd1);
`endif

      // MULT 2*3 with a stray start and mthi while busy.
      start = 1'b1;
      op = 2'd0;
      rs = 32'd2;
      rt = 32'd3;
      tick();
      start = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      chk("div0_clr", 64'(div0), 64'd0);
`endif
      repeat (4) tick();
      start = 1'b1;
      op = 2'd2;
      rs = 32'd9;
      rt = 32'd3;
      tick();
      start = 1'b0;
      repeat (2) tick();
      mthi = 1'b1;
      wr_data = 32'h1234_5678;
      tick();
      mthi = 1'b0;
      wait_done(lat);
      chk("busy_ign_lat", 64'(lat), 64'd25);
      chk("busy_ign_hi", 64'(hi), 64'd0);
      chk("busy_ign_lo", 64'(lo), 64'd6);

      mthi = 1'b1;
      wr_data = 32'hA5A5_A5A5;
      tick();
      mthi = 1'b0;
      chk("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
      chk("mthi_lo", 64'(lo), 64'd6);

      mtlo = 1'b1;
      mthi = 1'b1;
      wr_data = 32'hDEAD_BEEF;
      do_op("start_wins", 2'd1, 32'd3, 32'd4, 32'd0, 32'd12);
      do_op("div_z_raw", 2'd2, 32'hFFFF_FFF9, 32'd0,
            32'hFFFF_FFF9, 32'hFFFF_FFFF);
      do_op("b2b_mult", 2'd0, 32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32'h0);

      start = 1'b1;
      op = 2'd0;
      rs = 32'd7;
      rt = 32'd9;
      tick();
      start = 1'b0;
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_hi", 64'(hi), 64'd0);
      chk("abort_lo", 64'(lo), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("abort_no_done", 64'(seen), 64'd0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, in the EX stage directly downstream of the register file.
- Consumes the two register read operands (rs, rt) for MULT, MULTU, DIV and DIVU.
- Results are read back through the hi/lo outputs for MFHI/MFLO. MTHI/MTLO write them directly.
- Pipeline control stalls on busy.

Parameters:
- DATA_W, 32, operand/HI/LO width. Iteration count equals DATA_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request operation; accepted only when busy=0
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU; sampled with start
- rs_data  in  DATA_W  operand A: multiplicand / dividend
- rt_data  in  DATA_W  operand B: multiplier / divisor
- mthi  in  1  write wr_data to HI
- mtlo  in  1  write wr_data to LO
- wr_data  in  DATA_W  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including an operation in flight. After reset: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- States are IDLE, RUN, FIX.
- IDLE, start=1 at edge N:
  - latch op and sign flags
  - latch |rs|, |rt| for signed ops, raw values for unsigned ops
  - clear the partial result; counter=0; busy=1; go to RUN
- RUN, edges N+1..N+DATA_W: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. Counter increments each edge; go to FIX when the counter reaches DATA_W-1.
- FIX, edge N+DATA_W+1:
  - apply sign correction
  - write hi/lo
  - done=1 for exactly one cycle; busy=0; go to IDLE
  - total latency 33 cycles at DATA_W=32
- Multiply: {hi,lo} = full 2*DATA_W-bit product. MULT is two's-complement, MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- Divisor zero (DIV or DIVU): lo=all ones, hi=rs_data as latched (raw, unsigned). Same 33-cycle latency.
- start while busy=1: ignored. No queueing, and no change to the in-flight operation.
- start in the same cycle that done=1: accepted, since state is IDLE.
- mthi/mtlo:
  - take effect at the clock edge only when busy=0 and start=0
  - ignored while busy=1
  - if start=1 in the same cycle, start wins and mthi/mtlo are dropped
  - mthi and mtlo together write both registers
- hi/lo hold their value between completions and MT writes. They are not modified during RUN; intermediate state lives in internal registers only.
- done never asserts after a reset-aborted operation.

Optional Feature:
- Macro: MDU_DIV0_FLAG_EN.
- Defined: adds output div0 (1 bit). It is set at the FIX edge when a DIV/DIVU had divisor zero, and stays set until the next accepted start or reset. div0 resets to 0.
- Undefined: port absent. Division-by-zero results are unchanged, as above.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> done 33 cycles after start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for cycles 1-32.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=5, rt=0 -> lo=0xFFFFFFFF, hi=0x00000005; div0=1 when MDU_DIV0_FLAG_EN is defined, cleared on the next start.
- Start MULT 2*3, pulse start with op=DIV at cycle 5, assert mthi at cycle 8 -> both ignored; hi=0, lo=6. Then idle mthi with wr_data=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle, lo unchanged.
- Start MULT, assert reset at cycle 10 -> next cycle hi=lo=0, busy=0; done stays 0 for 40 further cycles.
